// File: rtl/madd_acc_if.sv
// Beat-stream bus for madd_acc: packed-lane input beats and grouped result words.
interface madd_acc_if #(
    parameter int LANES    = 2,
    parameter int LWIDTH   = 16,
    parameter int MAXBEATS = 8
);
    localparam int DWIDTH = LANES * LWIDTH;
    localparam int CW     = $clog2(MAXBEATS + 1);

    logic              i_valid;
    logic [DWIDTH-1:0] i_in;
    logic [CW-1:0]     i_beats;
    logic              i_sat_mode;
    logic              i_clear;
    logic [DWIDTH-1:0] o_out;
    logic              o_valid;
    logic [LANES-1:0]  o_ovf;
    logic              o_busy;

    modport master (
        output i_valid, i_in, i_beats, i_sat_mode, i_clear,
        input  o_out, o_valid, o_ovf, o_busy
    );

    modport slave (
        input  i_valid, i_in, i_beats, i_sat_mode, i_clear,
        output o_out, o_valid, o_ovf, o_busy
    );
endinterface

// File: rtl/madd_acc.sv
// Multi-lane packed accumulator: sums a programmable number of valid beats per
// lane with per-step wrap or symmetric saturation, one registered word per group.
module madd_acc #(
    parameter int LANES    = 2,
    parameter int LWIDTH   = 16,
    parameter int MAXBEATS = 8
) (
    input logic      clk,
    input logic      arst_n,
    madd_acc_if.slave bus
);
    localparam int CW = $clog2(MAXBEATS + 1);
    localparam logic [LWIDTH-1:0] SAT_POS = {1'b0, {(LWIDTH-1){1'b1}}};
    localparam logic [LWIDTH-1:0] SAT_NEG = {1'b1, {(LWIDTH-2){1'b0}}, 1'b1};

    typedef logic [LANES-1:0][LWIDTH-1:0] lanes_t;

    lanes_t           acc;
    lanes_t           in_lanes;
    lanes_t           sum_lanes;
    lanes_t           step_res;
    logic [LANES-1:0] step_ovf;
    logic [LANES-1:0] ovf_acc;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    beats_n;
    logic [CW-1:0]    first_beats;
    logic             sat_mode;
    logic             last_beat;

    assign in_lanes = bus.i_in;

    // Overflow is judged on operand/result sign bits; the clamp is symmetric
    // so -2^(LWIDTH-1) only ever appears as a genuine, non-overflowing sum.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign sum_lanes[k] = acc[k] + in_lanes[k];
        assign step_ovf[k]  = (acc[k][LWIDTH-1] == in_lanes[k][LWIDTH-1]) &&
                              (sum_lanes[k][LWIDTH-1] != acc[k][LWIDTH-1]);
        assign step_res[k]  = (step_ovf[k] && sat_mode) ?
                              (acc[k][LWIDTH-1] ? SAT_NEG : SAT_POS) : sum_lanes[k];
    end

    always_comb begin
        // NOTE: every output of this block is assigned a default first so no latch is inferred.
        first_beats = bus.i_beats;
        last_beat   = 1'b0;
        cnt_nxt     = cnt;
        if (bus.i_beats == '0) begin
            first_beats = CW'(1);
        end else if (bus.i_beats > CW'(MAXBEATS)) begin
            first_beats = CW'(MAXBEATS);
        end
        if (bus.i_clear) begin
            cnt_nxt = '0;
        end else if (bus.i_valid) begin
            if (cnt == '0) begin
                last_beat = (first_beats == CW'(1));
            end else begin
                last_beat = ((cnt + CW'(1)) == beats_n);
            end
            cnt_nxt = last_beat ? '0 : cnt + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt         <= '0;
            beats_n     <= '0;
            sat_mode    <= 1'b0;
            acc         <= '0;
            ovf_acc     <= '0;
            bus.o_out   <= '0;
            bus.o_valid <= 1'b0;
            bus.o_ovf   <= '0;
            bus.o_busy  <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            bus.o_busy  <= (cnt_nxt != '0);
            bus.o_valid <= 1'b0;
            if (bus.i_clear) begin
                acc     <= '0;
                ovf_acc <= '0;
            end else if (bus.i_valid) begin
                if (cnt == '0) begin
                    acc      <= in_lanes;
                    ovf_acc  <= '0;
                    beats_n  <= first_beats;
                    sat_mode <= bus.i_sat_mode;
                    if (last_beat) begin
                        bus.o_out   <= bus.i_in;
                        bus.o_ovf   <= '0;
                        bus.o_valid <= 1'b1;
                    end
                end else begin
                    acc     <= step_res;
                    ovf_acc <= ovf_acc | step_ovf;
                    if (last_beat) begin
                        bus.o_out   <= step_res;
                        bus.o_ovf   <= ovf_acc | step_ovf;
                        bus.o_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_madd_acc.sv
// Self-checking bench for madd_acc: directed scenarios plus randomized groups
// compared against an integer-arithmetic reference model.
module tb_madd_acc;
    localparam int LANES    = 2;
    localparam int LWIDTH   = 16;
    localparam int MAXBEATS = 8;
    localparam int DW       = LANES * LWIDTH;
    localparam int CW       = $clog2(MAXBEATS + 1);

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] grp [16];

    madd_acc_if #(.LANES(LANES), .LWIDTH(LWIDTH), .MAXBEATS(MAXBEATS)) bus ();

    madd_acc #(.LANES(LANES), .LWIDTH(LWIDTH), .MAXBEATS(MAXBEATS)) dut (
        .clk   (clk),
        .arst_n(arst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One beat presented for exactly one rising edge; returns on the following falling edge.
    task automatic send(input logic [DW-1:0] d, input int nb, input bit sat, input bit clr);
        bus.i_valid    = 1'b1;
        bus.i_in       = d;
        bus.i_beats    = CW'(nb);
        bus.i_sat_mode = sat;
        bus.i_clear    = clr;
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
    endtask

    function automatic int eff_beats(input int nb);
        if (nb == 0) return 1;
        if (nb > MAXBEATS) return MAXBEATS;
        return nb;
    endfunction

    // Reference: signed integer sums, range-checked after every step.
    function automatic void ref_group(input int n, input bit sat,
                                      output logic [DW-1:0] out, output logic [LANES-1:0] ovf);
        longint maxv = (longint'(1) <<< (LWIDTH - 1)) - 1;
        longint minv = -maxv - 1;
        longint span = 2 * (maxv + 1);
        out = '0;
        ovf = '0;
        for (int k = 0; k < LANES; k++) begin
            logic signed [LWIDTH-1:0] v;
            longint a;
            v = grp[0][k*LWIDTH +: LWIDTH];
            a = longint'(v);
            for (int i = 1; i < n; i++) begin
                v = grp[i][k*LWIDTH +: LWIDTH];
                a = a + longint'(v);
                if (a > maxv || a < minv) begin
                    ovf[k] = 1'b1;
                    if (sat) a = (a > 0) ? maxv : -maxv;
                    else     a = (a > maxv) ? a - span : a + span;
                end
            end
            out[k*LWIDTH +: LWIDTH] = LWIDTH'(a);
        end
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        logic [LWIDTH-1:0] l;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 3))
                0: l = LWIDTH'($urandom);
                1: begin
                    case ($urandom_range(0, 3))
                        0: l = {1'b0, {(LWIDTH-1){1'b1}}};
                        1: l = {1'b1, {(LWIDTH-1){1'b0}}};
                        2: l = {1'b1, {(LWIDTH-2){1'b0}}, 1'b1};
                        default: l = '1;
                    endcase
                end
                2: l = LWIDTH'($urandom_range(0, 40));
                default: l = -LWIDTH'($urandom_range(0, 40));
            endcase
            w[k*LWIDTH +: LWIDTH] = l;
        end
        return w;
    endfunction

    task automatic test_reset();
        checks++; if (bus.o_out !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", bus.o_out); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_ovf !== '0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.o_ovf); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    endtask

    task automatic test_basic();
        send(32'h0001FFFF, 2, 1'b1, 1'b0);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL basic_mid_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL basic_mid_busy got=%b exp=1", bus.o_busy); end
        send(32'h00020003, 2, 1'b1, 1'b0);
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", bus.o_valid); end
        checks++; if (bus.o_out !== 32'h00030002) begin failures++; $display("FAIL basic_out got=%h exp=00030002", bus.o_out); end
        checks++; if (bus.o_ovf !== 2'b00) begin failures++; $display("FAIL basic_ovf got=%b exp=00", bus.o_ovf); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", bus.o_busy); end
        @(negedge clk);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_len got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_out !== 32'h00030002) begin failures++; $display("FAIL basic_hold got=%h exp=00030002", bus.o_out); end
    endtask

    task automatic test_overflow();
        send(32'h70009000, 2, 1'b1, 1'b0);
        send(32'h2000A000, 2, 1'b0, 1'b0);
        checks++; if (bus.o_out !== 32'h7FFF8001) begin failures++; $display("FAIL sat_out got=%h exp=7fff8001", bus.o_out); end
        checks++; if (bus.o_ovf !== 2'b11) begin failures++; $display("FAIL sat_ovf got=%b exp=11", bus.o_ovf); end
        send(32'h70009000, 2, 1'b0, 1'b0);
        send(32'h2000A000, 2, 1'b1, 1'b0);
        checks++; if (bus.o_out !== 32'h90003000) begin failures++; $display("FAIL wrap_out got=%h exp=90003000", bus.o_out); end
        checks++; if (bus.o_ovf !== 2'b11) begin failures++; $display("FAIL wrap_ovf got=%b exp=11", bus.o_ovf); end
        send(32'h00007FFF, 3, 1'b1, 1'b0);
        send(32'h00000001, 3, 1'b1, 1'b0);
        send(32'h0000FFFF, 3, 1'b1, 1'b0);
        checks++; if (bus.o_out !== 32'h00007FFE) begin failures++; $display("FAIL perstep_out got=%h exp=00007ffe", bus.o_out); end
        checks++; if (bus.o_ovf !== 2'b01) begin failures++; $display("FAIL perstep_ovf got=%b exp=01", bus.o_ovf); end
    endtask

    task automatic test_stalls();
        int pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            send(DW'(i), 4, 1'b0, 1'b0);
            if (i < 4) begin
                checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL stall_busy beat=%0d got=%b exp=1", i, bus.o_busy); end
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL stall_idle_busy got=%b exp=1", bus.o_busy); end
                    if (bus.o_valid) pulses++;
                end
            end else begin
                if (bus.o_valid) pulses++;
                checks++; if (bus.o_out !== 32'h0000000A) begin failures++; $display("FAIL stall_out got=%h exp=0000000a", bus.o_out); end
                checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL stall_done_busy got=%b exp=0", bus.o_busy); end
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.o_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_single_beat();
        int nbs [2] = '{1, 0};
        for (int j = 0; j < 2; j++) begin
            for (int v = 5; v <= 7; v++) begin
                send(DW'(v), nbs[j], 1'b1, 1'b0);
                checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL single_valid nb=%0d v=%0d got=%b exp=1", nbs[j], v, bus.o_valid); end
                checks++; if (bus.o_out !== DW'(v)) begin failures++; $display("FAIL single_out nb=%0d got=%h exp=%h", nbs[j], bus.o_out, DW'(v)); end
            end
            @(negedge clk);
            checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL single_end got=%b exp=0", bus.o_valid); end
        end
    endtask

    task automatic test_clear();
        send(DW'(1), 4, 1'b0, 1'b0);
        send(DW'(2), 4, 1'b0, 1'b0);
        send(DW'(100), 4, 1'b0, 1'b1);
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL clear_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_out !== DW'(7)) begin failures++; $display("FAIL clear_out_kept got=%h exp=%h", bus.o_out, DW'(7)); end
        send(DW'(5), 2, 1'b0, 1'b0);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL clear_restart_valid got=%b exp=0", bus.o_valid); end
        send(DW'(6), 2, 1'b0, 1'b0);
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL clear_group_valid got=%b exp=1", bus.o_valid); end
        checks++; if (bus.o_out !== DW'(11)) begin failures++; $display("FAIL clear_group_out got=%h exp=%h", bus.o_out, DW'(11)); end
        // A clear in the cycle after completion leaves the registered pulse visible.
        bus.i_clear = 1'b1;
        #2;
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("FAIL clear_keeps_pulse got=%b exp=1", bus.o_valid); end
        @(negedge clk);
        bus.i_clear = 1'b0;
        checks++; if (bus.o_out !== DW'(11)) begin failures++; $display("FAIL clear_after_hold got=%h exp=%h", bus.o_out, DW'(11)); end
    endtask

    task automatic test_async_reset();
        send(DW'(9), 4, 1'b0, 1'b0);
        send(DW'(9), 4, 1'b0, 1'b0);
        #2 arst_n = 1'b0;
        #1;
        checks++; if (bus.o_out !== '0) begin failures++; $display("FAIL arst_out got=%h exp=0", bus.o_out); end
        checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.o_busy); end
        checks++; if (bus.o_ovf !== '0 || bus.o_valid !== 1'b0) begin failures++; $display("FAIL arst_flags got=%b/%b exp=0/0", bus.o_ovf, bus.o_valid); end
        @(negedge clk);
        arst_n = 1'b1;
        send(DW'(3), 2, 1'b0, 1'b0);
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("FAIL arst_fresh_mid got=%b exp=0", bus.o_valid); end
        send(DW'(4), 2, 1'b0, 1'b0);
        checks++; if (bus.o_out !== DW'(7) || bus.o_valid !== 1'b1) begin failures++; $display("FAIL arst_fresh_out got=%h/%b exp=%h/1", bus.o_out, bus.o_valid, DW'(7)); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_out;
        logic [LANES-1:0] exp_ovf;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 3; i++) grp[i] = rand_word();
            ref_group(3, 1'b1, exp_out, exp_ovf);
            for (int i = 0; i < 3; i++) send(grp[i], 3, 1'b1, 1'b0);
            checks++; if (bus.o_valid !== 1'b1 || bus.o_out !== exp_out || bus.o_ovf !== exp_ovf) begin
                failures++; $display("FAIL b2b g=%0d got=%b/%h/%b exp=1/%h/%b", g, bus.o_valid, bus.o_out, bus.o_ovf, exp_out, exp_ovf);
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_out;
        logic [LANES-1:0] exp_ovf;
        for (int g = 0; g < 60; g++) begin
            int nb0 = int'($urandom_range(0, MAXBEATS + 3));
            bit sat = 1'($urandom_range(0, 1));
            int n = eff_beats(nb0);
            for (int i = 0; i < n; i++) grp[i] = rand_word();
            ref_group(n, sat, exp_out, exp_ovf);
            for (int i = 0; i < n; i++) begin
                if (i == 0) send(grp[i], nb0, sat, 1'b0);
                else        send(grp[i], int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
                if (i < n - 1) begin
                    checks++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
                        failures++; $display("FAIL rand_mid g=%0d beat=%0d valid/busy got=%b/%b exp=0/1", g, i, bus.o_valid, bus.o_busy);
                    end
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                end else begin
                    checks++; if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b0) begin
                        failures++; $display("FAIL rand_done g=%0d valid/busy got=%b/%b exp=1/0", g, bus.o_valid, bus.o_busy);
                    end
                    checks++; if (bus.o_out !== exp_out || bus.o_ovf !== exp_ovf) begin
                        failures++; $display("FAIL rand_result g=%0d n=%0d sat=%0d got=%h/%b exp=%h/%b", g, n, sat, bus.o_out, bus.o_ovf, exp_out, exp_ovf);
                    end
                end
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_in       = '0;
        bus.i_beats    = '0;
        bus.i_sat_mode = 1'b0;
        bus.i_clear    = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        arst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_stalls();
        test_single_beat();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
